// File: rtl/sync_mem_dp.sv
// Dual-port synchronous unified memory: read-only I-port for fetch, read/byte-write D-port
// for load/store, with 1- or 2-cycle read latency, read-during-write mode and range errors.
module sync_mem_dp #(
    parameter int    DATA_W        = 32,
    parameter int    ADDR_W        = 32,
    parameter int    DEPTH_WORDS   = 32768,
    parameter string INIT_HEX_FILE = "",
    parameter int    READ_LATENCY  = 1,
    parameter int    RDW_MODE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_err,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W/8-1:0] d_mask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_err
);

    localparam int NB     = DATA_W / 8;
    localparam int LSB    = $clog2(NB);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

    logic [DATA_W-1:0] mem [0:DEPTH_WORDS-1];

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
            $error("sync_mem_dp: READ_LATENCY must be 1 or 2");
        end
        if (LSB > 0) begin : gLsbSink
            logic unusedAddrLsbs;
            assign unusedAddrLsbs = ^{i_addr[LSB-1:0], d_addr[LSB-1:0]};
        end
    endgenerate

    logic [IDX_W-1:0]  iIdx, dIdx;
    logic [MEM_AW-1:0] iWord, dWord;
    logic              iInRange, dInRange, dWrEn;
    logic [DATA_W-1:0] iReadVal, dReadVal;

    assign iIdx     = i_addr[ADDR_W-1:LSB];
    assign dIdx     = d_addr[ADDR_W-1:LSB];
    assign iWord    = iIdx[MEM_AW-1:0];
    assign dWord    = dIdx[MEM_AW-1:0];
    assign iInRange = ({1'b0, iIdx} < DEPTH_L);
    assign dInRange = ({1'b0, dIdx} < DEPTH_L);
    // Both indices are full-width range-checked, so truncated-word equality is a true match.
    assign dWrEn    = d_wen && dInRange && !rst;

    function automatic logic [DATA_W-1:0] mergeLanes(input logic [DATA_W-1:0] oldWord,
                                                     input logic [DATA_W-1:0] newWord,
                                                     input logic [NB-1:0]     mask);
        logic [DATA_W-1:0] r;
        r = oldWord;
        for (int k = 0; k < NB; k++) begin
            if (mask[k]) r[8*k +: 8] = newWord[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        iReadVal = '0;
        dReadVal = '0;
        if (iInRange) begin
            if (RDW_MODE == 1 && dWrEn && iWord == dWord)
                iReadVal = mergeLanes(mem[iWord], d_wdata, d_mask);
            else
                iReadVal = mem[iWord];
        end
        if (dInRange) begin
            if (RDW_MODE == 1 && dWrEn)
                dReadVal = mergeLanes(mem[dWord], d_wdata, d_mask);
            else
                dReadVal = mem[dWord];
        end
    end

    always_ff @(posedge clk) begin
        if (dWrEn) begin
            for (int k = 0; k < NB; k++) begin
                if (d_mask[k]) mem[dWord][8*k +: 8] <= d_wdata[8*k +: 8];
            end
        end
    end

    logic              i1Valid, i1Err, d1Valid, d1Err;
    logic [DATA_W-1:0] i1Data, d1Data;

    // Data registers only load on a read so they hold the last returned word between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1Valid <= 1'b0;
            i1Err   <= 1'b0;
            i1Data  <= '0;
            d1Valid <= 1'b0;
            d1Err   <= 1'b0;
            d1Data  <= '0;
        end else begin
            i1Valid <= i_ren;
            i1Err   <= i_ren && !iInRange;
            if (i_ren) i1Data <= iReadVal;
            d1Valid <= d_ren;
            d1Err   <= (d_ren || d_wen) && !dInRange;
            if (d_ren) d1Data <= dReadVal;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : gLat2
            logic              i2Valid, i2Err, d2Valid, d2Err;
            logic [DATA_W-1:0] i2Data, d2Data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    i2Valid <= 1'b0;
                    i2Err   <= 1'b0;
                    i2Data  <= '0;
                    d2Valid <= 1'b0;
                    d2Err   <= 1'b0;
                    d2Data  <= '0;
                end else begin
                    i2Valid <= i1Valid;
                    i2Err   <= i1Err;
                    if (i1Valid) i2Data <= i1Data;
                    d2Valid <= d1Valid;
                    d2Err   <= d1Err;
                    if (d1Valid) d2Data <= d1Data;
                end
            end

            assign i_rvalid = i2Valid;
            assign i_err    = i2Err;
            assign i_rdata  = i2Data;
            assign d_rvalid = d2Valid;
            assign d_err    = d2Err;
            assign d_rdata  = d2Data;
        end else begin : gLat1
            assign i_rvalid = i1Valid;
            assign i_err    = i1Err;
            assign i_rdata  = i1Data;
            assign d_rvalid = d1Valid;
            assign d_err    = d1Err;
            assign d_rdata  = d1Data;
        end
    endgenerate

endmodule

// File: tb/tb_sync_mem_dp.sv
// Bench for sync_mem_dp: four instances (RDW_MODE 0/1 x latency 1/2) share one stimulus
// stream and are compared every cycle against a behavioural memory model.
module tb_sync_mem_dp;

    localparam int NCFG  = 4;
    localparam int DEPTH = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ren, d_ren, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_mask;

    logic [31:0] iRdata  [NCFG];
    logic [31:0] dRdata  [NCFG];
    logic        iRvalid [NCFG];
    logic        iErr    [NCFG];
    logic        dRvalid [NCFG];
    logic        dErr    [NCFG];

    always #5 clk = ~clk;

    // cfg g: RDW_MODE = g % 2, READ_LATENCY = g / 2 + 1
    for (genvar g = 0; g < NCFG; g++) begin : gDut
        sync_mem_dp #(
            .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .INIT_HEX_FILE(""),
            .READ_LATENCY(g / 2 + 1), .RDW_MODE(g % 2)
        ) dut (
            .clk(clk), .rst(rst),
            .i_ren(i_ren), .i_addr(i_addr), .i_rdata(iRdata[g]),
            .i_rvalid(iRvalid[g]), .i_err(iErr[g]),
            .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_mask(d_mask), .d_rdata(dRdata[g]), .d_rvalid(dRvalid[g]), .d_err(dErr[g])
        );
    end

    // ---------------- scoreboard counters ----------------
    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            if (nFails <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) assert (!$isunknown({i_ren, d_ren, d_wen}))
            else $error("request strobe unknown outside reset");
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        v;
        logic        err;
        logic [31:0] old;
        logic [31:0] mrg;
    } rsp_t;

    logic [31:0] modelMem [DEPTH];
    rsp_t        prevI, prevD;
    logic        expIValid [NCFG];
    logic        expIErr   [NCFG];
    logic [31:0] expIData  [NCFG];
    logic        expDValid [NCFG];
    logic        expDErr   [NCFG];
    logic [31:0] expDData  [NCFG];

    // Response of one port for a request seen this edge: old word and write-merged word.
    function automatic rsp_t mkRsp(input logic req, input logic isRead, input logic [31:0] addr);
        rsp_t        r;
        int unsigned idx;
        idx   = addr >> 2;
        r.v   = isRead;
        r.err = req && (idx >= DEPTH);
        r.old = '0;
        r.mrg = '0;
        if (idx < DEPTH) begin
            r.old = modelMem[idx];
            r.mrg = r.old;
            if (d_wen && (d_addr >> 2) == idx) begin
                for (int k = 0; k < 4; k++)
                    if (d_mask[k]) r.mrg[8*k +: 8] = d_wdata[8*k +: 8];
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        rsp_t curI, curD, ri, rd;
        if (rst) begin
            prevI = '{default: '0};
            prevD = '{default: '0};
            for (int g = 0; g < NCFG; g++) begin
                expIValid[g] = 1'b0; expIErr[g] = 1'b0; expIData[g] = '0;
                expDValid[g] = 1'b0; expDErr[g] = 1'b0; expDData[g] = '0;
            end
        end else begin
            curI = mkRsp(i_ren, i_ren, i_addr);
            curD = mkRsp(d_ren || d_wen, d_ren, d_addr);
            for (int g = 0; g < NCFG; g++) begin
                ri = (g / 2 == 0) ? curI : prevI;
                rd = (g / 2 == 0) ? curD : prevD;
                expIValid[g] = ri.v;
                expIErr[g]   = ri.err;
                if (ri.v) expIData[g] = (g % 2 == 1) ? ri.mrg : ri.old;
                expDValid[g] = rd.v;
                expDErr[g]   = rd.err;
                if (rd.v) expDData[g] = (g % 2 == 1) ? rd.mrg : rd.old;
            end
            prevI = curI;
            prevD = curD;
            if (d_wen && (d_addr >> 2) < DEPTH) begin
                for (int k = 0; k < 4; k++)
                    if (d_mask[k]) modelMem[d_addr >> 2][8*k +: 8] = d_wdata[8*k +: 8];
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #2;
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("cfg%0d i_rvalid", g), 32'(iRvalid[g]), 32'(expIValid[g]));
            chk($sformatf("cfg%0d i_err", g),    32'(iErr[g]),    32'(expIErr[g]));
            chk($sformatf("cfg%0d i_rdata", g),  iRdata[g],       expIData[g]);
            chk($sformatf("cfg%0d d_rvalid", g), 32'(dRvalid[g]), 32'(expDValid[g]));
            chk($sformatf("cfg%0d d_err", g),    32'(dErr[g]),    32'(expDErr[g]));
            chk($sformatf("cfg%0d d_rdata", g),  dRdata[g],       expDData[g]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        i_ren  = 1'b0;
        d_ren  = 1'b0;
        d_wen  = 1'b0;
        d_mask = 4'h0;
    endtask

    task automatic driveWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        idle();
        d_wen   = 1'b1;
        d_addr  = addr;
        d_wdata = data;
        d_mask  = mask;
    endtask

    task automatic sampleAfterEdge();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        if ($urandom_range(0, 19) == 0) a = $urandom;
        else a = (32'($urandom_range(0, DEPTH + 39)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        idle();
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        #1 rst = 1'b1;
        #1;
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("reset cfg%0d i_rvalid", g), 32'(iRvalid[g]), 32'h0);
            chk($sformatf("reset cfg%0d d_rdata", g),  dRdata[g],       32'h0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // fill every word so all later reads are defined
        for (int w = 0; w < DEPTH; w++) driveWrite(32'(w) << 2, $urandom, 4'hF);

        // latency: word 4 read through the I-port
        driveWrite(32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk); idle(); i_ren = 1'b1; i_addr = 32'h10;
        sampleAfterEdge();
        chk("t1 lat1 i_rvalid", 32'(iRvalid[0]), 32'h1);
        chk("t1 lat1 i_rdata",  iRdata[0],       32'hDEADBEEF);
        chk("t1 lat2 not early", 32'(iRvalid[2]), 32'h0);
        @(negedge clk); idle();
        sampleAfterEdge();
        chk("t1 lat2 i_rvalid", 32'(iRvalid[2]), 32'h1);
        chk("t1 lat2 i_rdata",  iRdata[2],       32'hDEADBEEF);
        chk("t1 lat1 pulse",    32'(iRvalid[0]), 32'h0);
        chk("t1 lat1 hold",     iRdata[0],       32'hDEADBEEF);

        // byte-masked write
        driveWrite(32'h20, 32'h11223344, 4'hF);
        driveWrite(32'h20, 32'hAABBCCDD, 4'b0101);
        @(negedge clk); idle(); d_ren = 1'b1; d_addr = 32'h20;
        sampleAfterEdge();
        chk("t2 model d_rdata", expDData[0], 32'h11BB33DD);
        chk("t2 lat1 d_rdata",  dRdata[0],   32'h11BB33DD);
        @(negedge clk); idle();
        sampleAfterEdge();
        chk("t2 lat2 d_rdata",  dRdata[2],   32'h11BB33DD);

        // same-edge write + D read + I read of one word
        driveWrite(32'h40, 32'h0, 4'hF);
        driveWrite(32'h40, 32'hCAFEF00D, 4'hF);
        d_ren = 1'b1; i_ren = 1'b1; i_addr = 32'h40;
        sampleAfterEdge();
        chk("t3 rdw0 i_rdata", iRdata[0], 32'h00000000);
        chk("t3 rdw0 d_rdata", dRdata[0], 32'h00000000);
        chk("t3 rdw1 i_rdata", iRdata[1], 32'hCAFEF00D);
        chk("t3 rdw1 d_rdata", dRdata[1], 32'hCAFEF00D);
        chk("t3 model rdw1",   expIData[1], 32'hCAFEF00D);
        @(negedge clk); idle(); d_ren = 1'b1; d_addr = 32'h40;
        sampleAfterEdge();
        chk("t3 lat2 rdw0 i_rdata", iRdata[2], 32'h00000000);
        chk("t3 lat2 rdw1 i_rdata", iRdata[3], 32'hCAFEF00D);
        chk("t3 later read",        dRdata[0], 32'hCAFEF00D);

        // out-of-range accesses
        driveWrite(32'h0, 32'h12345678, 4'hF);
        @(negedge clk); idle();
        d_ren = 1'b1; d_addr = 32'hFA0; i_ren = 1'b1; i_addr = 32'hFA0;
        sampleAfterEdge();
        chk("t4 d_rvalid", 32'(dRvalid[0]), 32'h1);
        chk("t4 d_err",    32'(dErr[0]),    32'h1);
        chk("t4 d_rdata",  dRdata[0],       32'h0);
        chk("t4 i_err",    32'(iErr[0]),    32'h1);
        chk("t4 i_rdata",  iRdata[0],       32'h0);
        driveWrite(32'hFA0, 32'hFFFFFFFF, 4'hF);
        sampleAfterEdge();
        chk("t4 wr d_err",    32'(dErr[0]),    32'h1);
        chk("t4 wr d_rvalid", 32'(dRvalid[0]), 32'h0);
        driveWrite(32'h80000000, 32'hFFFFFFFF, 4'hF);
        sampleAfterEdge();
        chk("t4 alias d_err", 32'(dErr[0]), 32'h1);
        @(negedge clk); idle(); d_ren = 1'b1; d_addr = 32'h0;
        sampleAfterEdge();
        chk("t4 word0 kept", dRdata[0], 32'h12345678);
        chk("t4 word0 err",  32'(dErr[0]), 32'h0);

        // reset during back-to-back latency-2 reads
        @(negedge clk); idle(); i_ren = 1'b1; i_addr = 32'h0;
        @(negedge clk); i_addr = 32'h4;
        @(negedge clk); i_addr = 32'h8;
        sampleAfterEdge();
        rst = 1'b1;
        #1;
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("t5 cfg%0d i_rvalid", g), 32'(iRvalid[g]), 32'h0);
            chk($sformatf("t5 cfg%0d i_rdata", g),  iRdata[g],       32'h0);
        end
        @(negedge clk); i_addr = 32'hC; d_wen = 1'b1; d_addr = 32'h10; d_wdata = 32'h0; d_mask = 4'hF;
        @(negedge clk); i_addr = 32'h10;
        @(negedge clk); rst = 1'b0; idle();
        for (int c = 0; c < 3; c++) begin
            sampleAfterEdge();
            chk("t5 no late lat2 rdw0", 32'(iRvalid[2]), 32'h0);
            chk("t5 no late lat2 rdw1", 32'(iRvalid[3]), 32'h0);
        end
        @(negedge clk); i_ren = 1'b1; i_addr = 32'h10;
        @(negedge clk); idle();
        sampleAfterEdge();
        chk("t5 memory kept", iRdata[2], 32'hDEADBEEF);

        // randomized interleaved traffic with occasional async reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            i_ren   = 1'($urandom_range(0, 1));
            i_addr  = randAddr();
            d_ren   = 1'($urandom_range(0, 1));
            d_wen   = ($urandom_range(0, 2) == 0);
            d_addr  = ($urandom_range(0, 3) == 0) ? i_addr : randAddr();
            d_wdata = $urandom;
            d_mask  = 4'($urandom_range(0, 15));
        end
        @(negedge clk); idle(); rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
